key_debounce_events: RTL and testbench

Conditions the raw, bouncing, active-low DE0-Nano push-button (KEY_n[1]) before it reaches the counter/LED top level. It synchronises the key into the EXTCLK domain and debounces it with a 4-state FSM. Outputs are a clean pressed level, single-cycle press and release pulses, and an 8-bit press counter. It sits directly upstream of clk_counter_leds_top, which consumes the pulses as user events.

---
 rtl/key_debounce_events.sv | 120 ++++++++++++
 tb/tb_key_debounce_events.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_events.sv
// Push-button conditioner: 2-flop synchroniser, 4-state debounce FSM,
// registered press/release strobes and an 8-bit wrapping press counter.
module key_debounce_events #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       EXTCLK,
  input  logic       RST_n,
  input  logic       key_n_raw,
  output logic       key_pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    StReleased,
    StPressPending,
    StPressed,
    StReleasePending
  } state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic [7:0]       count_q, count_d;
  logic             key_s;

  // Synchroniser idles high so a released key is seen during and right after reset.
  always_ff @(posedge EXTCLK or negedge RST_n) begin
    if (!RST_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n_raw};
    end
  end

  assign key_s = ~sync_q[1];

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    count_d         = count_q;
    unique case (state_q)
      StReleased: begin
        if (key_s) begin
          state_d = StPressPending;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StPressPending: begin
        if (!key_s) begin
          state_d = StReleased;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d       = StPressed;
          cnt_d         = '0;
          press_pulse_d = 1'b1;
          count_d       = count_q + 8'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPressed: begin
        if (!key_s) begin
          state_d = StReleasePending;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StReleasePending: begin
        if (key_s) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d         = StReleased;
          cnt_d           = '0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StReleased;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge EXTCLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q         <= StReleased;
      cnt_q           <= '0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      count_q         <= 8'd0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      count_q         <= count_d;
    end
  end

  assign key_pressed   = (state_q == StPressed) || (state_q == StReleasePending);
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign press_count   = count_q;

endmodule

// File: tb/tb_key_debounce_events.sv
// Bench for key_debounce_events: run-length debounce model checked every cycle,
// plus directed scenarios with hand-computed edge positions.
module tb_key_debounce_events;

  localparam int unsigned D = 8;

  logic       EXTCLK;
  logic       RST_n;
  logic       key_n_raw;
  logic       key_pressed;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_count;

  key_debounce_events #(.DEBOUNCE_CYCLES(D)) dut (
    .EXTCLK       (EXTCLK),
    .RST_n        (RST_n),
    .key_n_raw    (key_n_raw),
    .key_pressed  (key_pressed),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count)
  );

  initial EXTCLK = 1'b0;
  always #5 EXTCLK = ~EXTCLK;

  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;
  int press_seen = 0;
  int release_seen = 0;
  bit chk_en = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge EXTCLK) edge_cnt <= edge_cnt + 1;

  // Model: the key is two samples late; a level flips after D consecutive
  // opposite samples, and any agreeing sample clears the run.
  logic [1:0] m_hist;
  logic       m_level, m_pp, m_rp;
  logic [7:0] m_cnt;
  int         m_run;

  always @(posedge EXTCLK or negedge RST_n) begin
    if (!RST_n) begin
      m_hist = 2'b11;
      m_level = 0; m_pp = 0; m_rp = 0; m_cnt = 0; m_run = 0;
    end else begin
      logic s;
      s = ~m_hist[1];
      m_pp = 0;
      m_rp = 0;
      if (s != m_level) m_run++;
      else m_run = 0;
      if (m_run == D) begin
        m_level = s;
        m_run = 0;
        if (s) begin
          m_pp = 1;
          m_cnt = m_cnt + 8'd1;
        end else begin
          m_rp = 1;
        end
      end
      m_hist = {m_hist[0], key_n_raw};
    end
  end

  always @(negedge EXTCLK) begin
    if (press_pulse === 1'b1) press_seen++;
    if (release_pulse === 1'b1) release_seen++;
    if (chk_en) begin
      check("model key_pressed", {31'd0, key_pressed}, {31'd0, m_level});
      check("model press_pulse", {31'd0, press_pulse}, {31'd0, m_pp});
      check("model release_pulse", {31'd0, release_pulse}, {31'd0, m_rp});
      check("model press_count", {24'd0, press_count}, {24'd0, m_cnt});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge EXTCLK);
    #1;
  endtask

  task automatic wait_ev(input bit rel, input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge EXTCLK);
      if ((rel ? release_pulse : press_pulse) === 1'b1) begin
        at = edge_cnt;
        break;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " key_pressed"}, {31'd0, key_pressed}, 32'd0);
    check({tag, " press_pulse"}, {31'd0, press_pulse}, 32'd0);
    check({tag, " release_pulse"}, {31'd0, release_pulse}, 32'd0);
    check({tag, " press_count"}, {24'd0, press_count}, 32'd0);
  endtask

  initial begin
    int k, at, p0, r0;
    RST_n = 1'b0;
    key_n_raw = 1'b0;
    step(3);
    check_reset_outputs("in reset");
    chk_en = 1;

    // Key held through reset release: re-debounced as a fresh press.
    k = edge_cnt;
    RST_n = 1'b1;
    wait_ev(0, 30, at);
    check("reset-held press edge", at, k + 10);
    check("reset-held press_count", {24'd0, press_count}, 32'd1);
    key_n_raw = 1'b1;
    wait_ev(1, 30, at);
    check("reset-held release seen", {31'd0, at != -1}, 32'd1);
    step(5);

    // Clean press then release.
    k = edge_cnt;
    key_n_raw = 1'b0;
    wait_ev(0, 30, at);
    check("clean press edge", at, k + 10);
    check("clean press key_pressed", {31'd0, key_pressed}, 32'd1);
    step(11);
    k = edge_cnt;
    key_n_raw = 1'b1;
    wait_ev(1, 30, at);
    check("clean release edge", at, k + 10);
    check("clean release key_pressed", {31'd0, key_pressed}, 32'd0);
    step(5);

    // Bounce: 3-cycle segments for 40 cycles, ending high, then held low.
    p0 = press_seen;
    r0 = release_seen;
    for (int i = 0; i < 40; i++) begin
      key_n_raw = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    check("bounce no press", press_seen - p0, 32'd0);
    check("bounce no release", release_seen - r0, 32'd0);
    k = edge_cnt;
    key_n_raw = 1'b0;
    wait_ev(0, 30, at);
    check("bounce press edge", at, k + 10);
    check("bounce press_count", {24'd0, press_count}, 32'd3);
    key_n_raw = 1'b1;
    wait_ev(1, 30, at);
    step(5);

    // Glitches: 7 samples rejected, 8 accepted.
    p0 = press_seen;
    r0 = release_seen;
    key_n_raw = 1'b0;
    step(7);
    key_n_raw = 1'b1;
    step(20);
    check("glitch7 no press", press_seen - p0, 32'd0);
    check("glitch7 key_pressed", {31'd0, key_pressed}, 32'd0);
    key_n_raw = 1'b0;
    step(8);
    key_n_raw = 1'b1;
    step(20);
    check("glitch8 one press", press_seen - p0, 32'd1);
    check("glitch8 one release", release_seen - r0, 32'd1);
    check("glitch8 press_count", {24'd0, press_count}, 32'd4);

    // Wrap: 256 presses from a fresh reset.
    RST_n = 1'b0;
    step(1);
    RST_n = 1'b1;
    step(2);
    p0 = press_seen;
    r0 = release_seen;
    for (int i = 1; i <= 256; i++) begin
      key_n_raw = 1'b0;
      step(12);
      if (i == 255) check("wrap count at 255", {24'd0, press_count}, 32'd255);
      if (i == 256) check("wrap count at 256", {24'd0, press_count}, 32'd0);
      key_n_raw = 1'b1;
      step(12);
    end
    check("wrap press strobes", press_seen - p0, 32'd256);
    check("wrap release strobes", release_seen - r0, 32'd256);

    // Asynchronous reset with the debounce count at 5.
    key_n_raw = 1'b0;
    step(7);
    #2;
    RST_n = 1'b0;
    #1;
    check_reset_outputs("async reset");
    step(3);
    check_reset_outputs("async reset held");

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
